// File: rtl/raytracer_pkg.sv
// Shared types and helpers for the DDA ray marcher: FSM encoding,
// empty-tile constant and width helpers for grid and step counters.
`timescale 1ns/1ps
package raytracer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FETCH = 3'd2,
    S_CHECK = 3'd3,
    S_STEP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int TILE_EMPTY = 0;

  function automatic int grid_w(input int pos_w, input int cell_shift);
    return pos_w - cell_shift;
  endfunction

  function automatic int steps_w(input int max_steps);
    return $clog2(max_steps + 1);
  endfunction

endpackage

// File: rtl/raytracer_dda_if.sv
// Trace request/result and tile RAM signals of the ray marcher.
// slave = the marcher itself, master = caller plus tile RAM.
`timescale 1ns/1ps
interface raytracer_dda_if
  import raytracer_pkg::*;
#(
  parameter int POS_W_X    = 14,
  parameter int POS_W_Y    = 13,
  parameter int CELL_SHIFT = 8,
  parameter int TILE_W     = 3,
  parameter int MAX_STEPS  = 64
);
  localparam int GXW = grid_w(POS_W_X, CELL_SHIFT);
  localparam int GYW = grid_w(POS_W_Y, CELL_SHIFT);
  localparam int SW  = steps_w(MAX_STEPS);

  logic               start;
  logic               cancel;
  logic [POS_W_X-1:0] pos_x;
  logic [POS_W_Y-1:0] pos_y;
  logic [POS_W_X:0]   dir_x;
  logic [POS_W_Y:0]   dir_y;
  logic               busy;
  logic               done;
  logic               hit;
  logic               oob;
  logic               timeout;
  logic [GXW-1:0]     result_x;
  logic [GYW-1:0]     result_y;
  logic [TILE_W-1:0]  result_tile;
  logic [SW-1:0]      steps;
  logic [GXW-1:0]     grid_x;
  logic [GYW-1:0]     grid_y;
  logic [TILE_W-1:0]  grid_out;

  modport slave (
    input  start, cancel, pos_x, pos_y, dir_x, dir_y, grid_out,
    output busy, done, hit, oob, timeout, result_x, result_y, result_tile,
           steps, grid_x, grid_y
  );

  modport master (
    output start, cancel, pos_x, pos_y, dir_x, dir_y, grid_out,
    input  busy, done, hit, oob, timeout, result_x, result_y, result_tile,
           steps, grid_x, grid_y
  );

endinterface

// File: rtl/raytracer_dda_step.sv
// One axis of the march: unsigned position plus signed step, with a flag
// when the result leaves [0, 2^POS_W).
`timescale 1ns/1ps
module raytracer_dda_step #(
  parameter int POS_W = 14
) (
  input  logic [POS_W-1:0] pos,
  input  logic [POS_W:0]   dir,
  output logic [POS_W-1:0] pos_next,
  output logic             oob
);
  // Two guard bits: bit POS_W+1 is the sign, bit POS_W flags overflow past the map.
  logic [POS_W+1:0] sum;

  assign sum      = {2'b00, pos} + {dir[POS_W], dir};
  assign pos_next = sum[POS_W-1:0];
  assign oob      = sum[POS_W+1] | sum[POS_W];

endmodule

// File: rtl/raytracer_dda.sv
// Fixed-step ray marcher: walks a ray through the tile map one step per
// iteration until a solid tile, the map edge, the step budget or a cancel.
`timescale 1ns/1ps
module raytracer_dda
  import raytracer_pkg::*;
#(
  parameter int POS_W_X     = 14,
  parameter int POS_W_Y     = 13,
  parameter int CELL_SHIFT  = 8,
  parameter int TILE_W      = 3,
  parameter int MAX_STEPS   = 64,
  parameter int MEM_LATENCY = 0
) (
  input logic           clock,
  input logic           reset,
  raytracer_dda_if.slave bus
);
  localparam int GXW = grid_w(POS_W_X, CELL_SHIFT);
  localparam int GYW = grid_w(POS_W_Y, CELL_SHIFT);
  localparam int SW  = steps_w(MAX_STEPS);
  localparam logic [SW-1:0]     STEP_LIMIT = SW'(MAX_STEPS);
  localparam logic [TILE_W-1:0] EMPTY      = TILE_W'(TILE_EMPTY);
  localparam logic [1:0]        LAT_LAST   = 2'(MEM_LATENCY - 1);
  localparam state_t            AFTER_MOVE = (MEM_LATENCY > 0) ? S_FETCH : S_CHECK;

  state_t              state_reg, state_next;
  logic [POS_W_X-1:0]  pos_x_reg, next_x;
  logic [POS_W_Y-1:0]  pos_y_reg, next_y;
  logic [POS_W_X:0]    dir_x_reg;
  logic [POS_W_Y:0]    dir_y_reg;
  logic [SW-1:0]       step_cnt_reg, step_cnt_inc;
  logic [1:0]          lat_cnt_reg;
  logic                oob_x, oob_y;
  logic                hit_reg, oob_reg, timeout_reg;
  logic                hit_next, oob_next, timeout_next;
  logic [GXW-1:0]      res_x_reg;
  logic [GYW-1:0]      res_y_reg;
  logic [TILE_W-1:0]   res_tile_reg;
  logic [SW-1:0]       steps_reg;
  logic                load_en, step_en, finish_en;

  raytracer_dda_step #(.POS_W(POS_W_X)) u_step_x (
    .pos(pos_x_reg), .dir(dir_x_reg), .pos_next(next_x), .oob(oob_x)
  );
  raytracer_dda_step #(.POS_W(POS_W_Y)) u_step_y (
    .pos(pos_y_reg), .dir(dir_y_reg), .pos_next(next_y), .oob(oob_y)
  );

  assign step_cnt_inc = step_cnt_reg + 1'b1;

  always_comb begin
    state_next   = state_reg;
    load_en      = 1'b0;
    step_en      = 1'b0;
    finish_en    = 1'b0;
    hit_next     = 1'b0;
    oob_next     = 1'b0;
    timeout_next = 1'b0;
    case (state_reg)
      S_IDLE:  if (bus.start && !bus.cancel) state_next = S_LOAD;
      S_LOAD: begin
        load_en    = 1'b1;
        state_next = AFTER_MOVE;
      end
      S_FETCH: if (lat_cnt_reg == LAT_LAST) state_next = S_CHECK;
      S_CHECK: begin
        if (bus.grid_out != EMPTY) begin
          hit_next   = 1'b1;
          finish_en  = 1'b1;
          state_next = S_DONE;
        end else if (step_cnt_reg == STEP_LIMIT) begin
          timeout_next = 1'b1;
          finish_en    = 1'b1;
          state_next   = S_DONE;
        end else begin
          state_next = S_STEP;
        end
      end
      S_STEP: begin
        step_en = 1'b1;
        if (oob_x || oob_y) begin
          oob_next   = 1'b1;
          finish_en  = 1'b1;
          state_next = S_DONE;
        end else begin
          state_next = AFTER_MOVE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // A cancelled trace leaves no trace of itself in the result registers.
    if (state_reg != S_IDLE && bus.cancel) begin
      state_next = S_IDLE;
      load_en    = 1'b0;
      step_en    = 1'b0;
      finish_en  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      pos_x_reg    <= '0;
      pos_y_reg    <= '0;
      dir_x_reg    <= '0;
      dir_y_reg    <= '0;
      step_cnt_reg <= '0;
      lat_cnt_reg  <= '0;
      hit_reg      <= 1'b0;
      oob_reg      <= 1'b0;
      timeout_reg  <= 1'b0;
      res_x_reg    <= '0;
      res_y_reg    <= '0;
      res_tile_reg <= '0;
      steps_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_FETCH && state_next == S_FETCH) lat_cnt_reg <= lat_cnt_reg + 1'b1;
      else                                               lat_cnt_reg <= '0;
      if (load_en) begin
        pos_x_reg    <= bus.pos_x;
        pos_y_reg    <= bus.pos_y;
        dir_x_reg    <= bus.dir_x;
        dir_y_reg    <= bus.dir_y;
        step_cnt_reg <= '0;
      end
      if (step_en) begin
        step_cnt_reg <= step_cnt_inc;
        if (!(oob_x || oob_y)) begin
          pos_x_reg <= next_x;
          pos_y_reg <= next_y;
        end
      end
      if (finish_en) begin
        hit_reg      <= hit_next;
        oob_reg      <= oob_next;
        timeout_reg  <= timeout_next;
        res_x_reg    <= pos_x_reg[POS_W_X-1:CELL_SHIFT];
        res_y_reg    <= pos_y_reg[POS_W_Y-1:CELL_SHIFT];
        res_tile_reg <= hit_next ? bus.grid_out : EMPTY;
        steps_reg    <= step_en ? step_cnt_inc : step_cnt_reg;
      end
    end
  end

  assign bus.busy        = (state_reg != S_IDLE);
  assign bus.done        = (state_reg == S_DONE);
  assign bus.hit         = hit_reg;
  assign bus.oob         = oob_reg;
  assign bus.timeout     = timeout_reg;
  assign bus.result_x    = res_x_reg;
  assign bus.result_y    = res_y_reg;
  assign bus.result_tile = res_tile_reg;
  assign bus.steps       = steps_reg;
  assign bus.grid_x      = pos_x_reg[POS_W_X-1:CELL_SHIFT];
  assign bus.grid_y      = pos_y_reg[POS_W_Y-1:CELL_SHIFT];

endmodule
